// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared opcode constants and loader state encoding for the
//               instruction path (loader and main decoder).
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // Major opcodes supported by the core's main decoder (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Program loader states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/opcode_legal_chk.sv
`default_nettype none
// ============================================================================
// Module      : opcode_legal_chk
// Description : Combinational check of a 7-bit major opcode against the set
//               the main decoder implements. Shared with the decoder for
//               illegal-instruction detection.
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_legal_chk
    import rv_pkg::*;
(
    input  logic [6:0] op,
    output logic       legal
);

    // Flag opcodes the decoder understands; everything else is illegal
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE,
            OP_BRANCH, OP_ITYPE, OP_JAL: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Loads a program into instruction memory from a little-endian
//               byte stream (valid/ready), writing one 32-bit word per 4
//               bytes to sequential addresses. Holds the core in reset until
//               the load completes and counts words with unsupported opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import rv_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   illegal_cnt,
    output logic [ADDR_W-1:0] first_illegal_addr
);

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    ld_state_e         state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   illegal_cnt_q, illegal_cnt_d;
    logic [ADDR_W-1:0] first_illegal_addr_q, first_illegal_addr_d;
    logic              op_legal;

    opcode_legal_chk u_opcode_legal_chk (
        .op    (mem_wdata_q[6:0]),
        .legal (op_legal)
    );

    // Next-state logic; status outputs are derived from the next state so
    // they are registered and line up with the state they describe
    always_comb begin
        state_d              = state_q;
        byte_idx_d           = byte_idx_q;
        word_idx_d           = word_idx_q;
        word_cnt_d           = word_cnt_q;
        mem_addr_d           = mem_addr_q;
        mem_wdata_d          = mem_wdata_q;
        illegal_cnt_d        = illegal_cnt_q;
        first_illegal_addr_d = first_illegal_addr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mem_addr_d           = BASE_ADDR;
                    byte_idx_d           = 2'd0;
                    word_idx_d           = '0;
                    word_cnt_d           = word_count;
                    illegal_cnt_d        = '0;
                    first_illegal_addr_d = '0;
                    state_d              = (word_count == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (s_valid && s_ready_q) begin
                    // Little-endian: byte k lands in bits [8k+7:8k]
                    mem_wdata_d[{byte_idx_q, 3'b000} +: 8] = s_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (!op_legal) begin
                    illegal_cnt_d = illegal_cnt_q + CNT_ONE;
                    if (illegal_cnt_q == '0) begin
                        first_illegal_addr_d = mem_addr_q;
                    end
                end
                if (word_idx_q == (word_cnt_q - CNT_ONE)) begin
                    state_d = ST_DONE;
                end else begin
                    // Address wraps naturally at 2^ADDR_W
                    mem_addr_d = mem_addr_q + ADDR_ONE;
                    word_idx_d = word_idx_q + CNT_ONE;
                    state_d    = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d   = (state_d == ST_RECV);
        mem_we_d    = (state_d == ST_WRITE);
        busy_d      = (state_d == ST_RECV) || (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        cpu_rst_n_d = (state_d == ST_DONE);
    end

    // State and output registers; async reset abandons any load in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= ST_IDLE;
            byte_idx_q           <= 2'd0;
            word_idx_q           <= '0;
            word_cnt_q           <= '0;
            s_ready_q            <= 1'b0;
            mem_we_q             <= 1'b0;
            mem_addr_q           <= BASE_ADDR;
            mem_wdata_q          <= '0;
            cpu_rst_n_q          <= 1'b0;
            busy_q               <= 1'b0;
            done_q               <= 1'b0;
            illegal_cnt_q        <= '0;
            first_illegal_addr_q <= '0;
        end else begin
            state_q              <= state_d;
            byte_idx_q           <= byte_idx_d;
            word_idx_q           <= word_idx_d;
            word_cnt_q           <= word_cnt_d;
            s_ready_q            <= s_ready_d;
            mem_we_q             <= mem_we_d;
            mem_addr_q           <= mem_addr_d;
            mem_wdata_q          <= mem_wdata_d;
            cpu_rst_n_q          <= cpu_rst_n_d;
            busy_q               <= busy_d;
            done_q               <= done_d;
            illegal_cnt_q        <= illegal_cnt_d;
            first_illegal_addr_q <= first_illegal_addr_d;
        end
    end

    assign s_ready            = s_ready_q;
    assign mem_we             = mem_we_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign cpu_rst_n          = cpu_rst_n_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign illegal_cnt        = illegal_cnt_q;
    assign first_illegal_addr = first_illegal_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader. Instance A uses
//               the default 10-bit address; instance B uses a 2-bit address
//               to exercise wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        start_a, start_b;
    logic [10:0] wc_a;
    logic [2:0]  wc_b;

    logic        s_valid_a, s_valid_b, cur_ready;
    logic        ready_a, we_a, cpurst_a, busy_a, done_a;
    logic [9:0]  addr_a, fia_a;
    logic [31:0] wdata_a;
    logic [10:0] ill_a;
    logic        ready_b, we_b, cpurst_b, busy_b, done_b;
    logic [1:0]  addr_b, fia_b;
    logic [31:0] wdata_b;
    logic [2:0]  ill_b;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:3];
    int          we_cnt_a = 0;
    int          we_cnt_b = 0;
    logic [1:0]  last_addr_b = 2'd3;
    int          base_a;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign s_valid_a = s_valid & ~sel;
    assign s_valid_b = s_valid & sel;
    assign cur_ready = sel ? ready_b : ready_a;

    prog_loader u_dut_a (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start_a),
        .word_count         (wc_a),
        .s_valid            (s_valid_a),
        .s_data             (s_data),
        .s_ready            (ready_a),
        .mem_we             (we_a),
        .mem_addr           (addr_a),
        .mem_wdata          (wdata_a),
        .cpu_rst_n          (cpurst_a),
        .busy               (busy_a),
        .done               (done_a),
        .illegal_cnt        (ill_a),
        .first_illegal_addr (fia_a)
    );

    prog_loader #(.ADDR_W(2)) u_dut_b (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start_b),
        .word_count         (wc_b),
        .s_valid            (s_valid_b),
        .s_data             (s_data),
        .s_ready            (ready_b),
        .mem_we             (we_b),
        .mem_addr           (addr_b),
        .mem_wdata          (wdata_b),
        .cpu_rst_n          (cpurst_b),
        .busy               (busy_b),
        .done               (done_b),
        .illegal_cnt        (ill_b),
        .first_illegal_addr (fia_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory model: capture every write strobe away from the clock edge
    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            mem_a[addr_a] <= wdata_a;
            we_cnt_a      <= we_cnt_a + 1;
            check("ready_low_in_write_a", {31'd0, ready_a}, 32'd0);
        end
        if (we_b === 1'b1) begin
            mem_b[addr_b] <= wdata_b;
            we_cnt_b      <= we_cnt_b + 1;
            last_addr_b   <= addr_b;
        end
    end

    task automatic start_load(input int wc);
        if (sel) begin
            wc_b    = wc[2:0];
            start_b = 1'b1;
        end else begin
            wc_a    = wc[10:0];
            start_a = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Present a byte after 'gap' idle cycles and hold it until accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        s_valid = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (cur_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check("byte_accept_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        start_a = 1'b0; start_b = 1'b0; wc_a = '0; wc_b = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_s_ready",   {31'd0, ready_a},  32'd0);
        check("rst_mem_we",    {31'd0, we_a},     32'd0);
        check("rst_mem_addr",  {22'd0, addr_a},   32'd0);
        check("rst_mem_wdata", wdata_a,           32'd0);
        check("rst_cpu_rst_n", {31'd0, cpurst_a}, 32'd0);
        check("rst_busy",      {31'd0, busy_a},   32'd0);
        check("rst_done",      {31'd0, done_a},   32'd0);
        check("rst_ill_cnt",   {21'd0, ill_a},    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load, s_valid continuously high
        base_a = we_cnt_a;
        start_load(2);
        check("basic_busy",      {31'd0, busy_a},   32'd1);
        check("basic_cpu_rst_n", {31'd0, cpurst_a}, 32'd0);
        send_word(32'h00A00513, 0);
        send_word(32'h00100593, 0);
        check("basic_done_early", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        check("basic_done",      {31'd0, done_a},   32'd1);
        check("basic_cpu_rst_n1",{31'd0, cpurst_a}, 32'd1);
        check("basic_busy_off",  {31'd0, busy_a},   32'd0);
        check("basic_mem0",      mem_a[0],          32'h00A00513);
        check("basic_mem1",      mem_a[1],          32'h00100593);
        check("basic_we_cnt",    we_cnt_a - base_a, 32'd2);
        check("basic_ill_cnt",   {21'd0, ill_a},    32'd0);

        // Same program with 3-cycle gaps between every byte; restart from DONE
        base_a = we_cnt_a;
        start_load(2);
        check("gap_done_cleared", {31'd0, done_a},   32'd0);
        check("gap_cpu_rst_n",    {31'd0, cpurst_a}, 32'd0);
        send_word(32'h00A00513, 3);
        send_word(32'h00100593, 3);
        @(negedge clk);
        check("gap_done",   {31'd0, done_a},   32'd1);
        check("gap_mem0",   mem_a[0],          32'h00A00513);
        check("gap_mem1",   mem_a[1],          32'h00100593);
        check("gap_we_cnt", we_cnt_a - base_a, 32'd2);

        // Illegal opcodes: word1 and word2 unsupported
        base_a = we_cnt_a;
        start_load(3);
        send_word(32'h00000013, 0);
        send_word(32'h0000007F, 0);
        send_word(32'hFFFFFFFF, 0);
        @(negedge clk);
        check("ill_done",   {31'd0, done_a},   32'd1);
        check("ill_cnt",    {21'd0, ill_a},    32'd2);
        check("ill_first",  {22'd0, fia_a},    32'd1);
        check("ill_mem0",   mem_a[0],          32'h00000013);
        check("ill_mem1",   mem_a[1],          32'h0000007F);
        check("ill_mem2",   mem_a[2],          32'hFFFFFFFF);
        check("ill_we_cnt", we_cnt_a - base_a, 32'd3);

        // Zero-length load: straight to DONE, counters cleared
        base_a = we_cnt_a;
        start_load(0);
        check("zero_done",   {31'd0, done_a},   32'd1);
        check("zero_busy",   {31'd0, busy_a},   32'd0);
        check("zero_ill",    {21'd0, ill_a},    32'd0);
        check("zero_first",  {22'd0, fia_a},    32'd0);
        check("zero_we_cnt", we_cnt_a - base_a, 32'd0);

        // Restart from DONE with one word
        base_a = we_cnt_a;
        start_load(1);
        check("one_cpu_rst_n", {31'd0, cpurst_a}, 32'd0);
        check("one_done",      {31'd0, done_a},   32'd0);
        check("one_addr",      {22'd0, addr_a},   32'd0);
        send_word(32'h00000033, 0);
        @(negedge clk);
        check("one_done1",  {31'd0, done_a},   32'd1);
        check("one_mem0",   mem_a[0],          32'h00000033);
        check("one_we_cnt", we_cnt_a - base_a, 32'd1);

        // Ignored start after 2 bytes, then reset after 6 bytes
        base_a = we_cnt_a;
        start_load(2);
        send_byte(8'h03, 0);
        send_byte(8'h56, 0);
        wc_a    = 11'd5;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("ign_busy", {31'd0, busy_a}, 32'd1);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_s_ready",   {31'd0, ready_a},  32'd0);
        check("mrst_mem_we",    {31'd0, we_a},     32'd0);
        check("mrst_addr",      {22'd0, addr_a},   32'd0);
        check("mrst_wdata",     wdata_a,           32'd0);
        check("mrst_cpu_rst_n", {31'd0, cpurst_a}, 32'd0);
        check("mrst_busy",      {31'd0, busy_a},   32'd0);
        check("mrst_done",      {31'd0, done_a},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ign_mem0",   mem_a[0],          32'h12345603);
        check("ign_we_cnt", we_cnt_a - base_a, 32'd1);

        // Wrap: 2-bit address, five words, fifth lands at address 0
        sel = 1'b1;
        start_load(5);
        for (int k = 0; k < 5; k++) send_word(32'h00000013 | (32'(k) << 20), 0);
        @(negedge clk);
        check("wrap_done",      {31'd0, done_b},   32'd1);
        check("wrap_cpu_rst_n", {31'd0, cpurst_b}, 32'd1);
        check("wrap_we_cnt",    we_cnt_b,          32'd5);
        check("wrap_last_addr", {30'd0, last_addr_b}, 32'd0);
        check("wrap_mem0",      mem_b[0],          32'h00400013);
        check("wrap_mem1",      mem_b[1],          32'h00100013);
        check("wrap_mem3",      mem_b[3],          32'h00300013);
        check("wrap_ill",       {29'd0, ill_b},    32'd0);
        check("wrap_first",     {30'd0, fia_b},    32'd0);
        check("wrap_busy",      {31'd0, busy_b},   32'd0);
        sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction path. It loads a program into instruction memory, which the fetch/decode path later reads.
- It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words and writes them to sequential word addresses.
- It holds the core in reset until the load completes.
- It flags any word whose opcode field is not one of the six opcodes the core's main decoder supports.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written (ADDR_W bits).

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins a load.
- word_count, input, ADDR_W+1, number of words to load; sampled on the accepted start.
- s_valid, input, 1, byte available.
- s_data, input, 8, byte value.
- s_ready, output, 1, loader can accept a byte.
- mem_we, output, 1, instruction-memory write strobe.
- mem_addr, output, ADDR_W, word address.
- mem_wdata, output, 32, assembled word.
- cpu_rst_n, output, 1, active-low reset to the core.
- busy, output, 1, load in progress.
- done, output, 1, load complete; held until next start.
- illegal_cnt, output, ADDR_W+1, count of words with an unsupported opcode.
- first_illegal_addr, output, ADDR_W, address of the first such word.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; s_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_rst_n=0, busy=0, done=0, illegal_cnt=0, first_illegal_addr=0.
  - Reset mid-load abandons the load; words already written stay in memory.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start=1 with word_count=0 -> DONE.
  - start=1 with word_count>0 -> RECV.
  - On start: mem_addr=BASE_ADDR, byte index=0, word index=0, illegal_cnt=0, first_illegal_addr=0.
- RECV:
  - s_ready=1, busy=1, cpu_rst_n=0.
  - A byte is accepted only when s_valid && s_ready.
  - Byte k (0..3) goes into mem_wdata[8k+7:8k]; byte 0 is the LSB.
  - When the 4th byte is accepted -> WRITE. The complete word is in mem_wdata on the next cycle.
- WRITE:
  - Exactly one cycle: mem_we=1, s_ready=0.
  - Opcode check on mem_wdata[6:0]:
    - Legal set: 0000011, 0100011, 0110011, 1100011, 0010011, 1101111.
    - Any other value increments illegal_cnt.
    - If illegal_cnt==0 in this cycle, also capture first_illegal_addr=mem_addr.
    - Illegal words are still written.
  - If word index == word_count-1 -> DONE.
  - Otherwise mem_addr+1 (wraps modulo 2^ADDR_W), word index+1 -> RECV.
- DONE:
  - done=1, busy=0, cpu_rst_n=1, s_ready=0.
  - Remains in DONE until start.
  - start in DONE behaves as start in IDLE: done=0 and cpu_rst_n=0 on the next cycle.
- start while in RECV or WRITE is ignored.
- Throughput: 5 cycles per word minimum (4 accept + 1 write).
- Latency: the last accepted byte to done=1 is 2 cycles.
- s_valid gaps stall RECV indefinitely, with no timeout.
- Bytes presented while s_ready=0 are not consumed; the source must hold them.
- mem_we is never high outside WRITE.
- word_count > 2^ADDR_W wraps addresses and overwrites earlier words. This is permitted, not flagged.

Decomposition:
- Shared package (rv_pkg):
  - Opcode localparams OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL. The main decoder must use the same constants.
  - Loader state enum typedef.
- One sub-module: opcode_legal_chk, a combinational op[6:0] -> legal flag, reusable by the decoder for illegal-instruction detection.

Test Plan:
- Basic load:
  - Stimulus: word_count=2, bytes 13 05 A0 00 93 05 10 00, s_valid always high.
  - Required response:
    - Writes 0x00A00513 @0 and 0x00100593 @1, one mem_we each.
    - done=1 and cpu_rst_n=1 two cycles after the last byte; illegal_cnt=0.
- Backpressure/gaps:
  - Stimulus: the same 8 bytes with s_valid dropped for 3 cycles between every byte.
  - Required response: identical memory contents; no byte lost or duplicated; s_ready=0 during each WRITE cycle.
- Illegal opcode:
  - Stimulus: 3 words 0x00000013, 0x0000007F, 0xFFFFFFFF.
  - Required response: illegal_cnt=2, first_illegal_addr=1, all 3 words written.
- Zero/restart:
  - Stimulus: start with word_count=0.
  - Required response: DONE the next cycle with no mem_we.
  - Stimulus: start again in DONE with word_count=1.
  - Required response: cpu_rst_n falls the next cycle, the word is written @BASE_ADDR, and the counters are cleared.
- Ignored start / mid-load reset:
  - Stimulus: a start pulse after 2 bytes.
  - Required response: no effect.
  - Stimulus: rst_n low after 6 bytes.
  - Required response: all outputs immediately at reset values, cpu_rst_n=0, and only the first word (@BASE_ADDR) was written.
- Wrap:
  - Stimulus: ADDR_W=2, word_count=5.
  - Required response: 5th word written @0.
